// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Fixed-latency instruction/data memory responder. It accepts one access at a
//   time, completes it exactly LATENCY cycles after acceptance with a one-cycle
//   done pulse, and supports squashing an in-flight access with flush.
//
//   Handshake: a request is taken in any cycle where req=1, flush=0 and the
//   responder is not busy (IDLE or RESP). While stall=1, req is ignored and
//   must be re-presented by the requester. done is a one-cycle pulse; err
//   can only be high together with done.
//
//   Optional feature (macro IMEM_UNALIGNED_ERR_EN): when defined, an access
//   with addr[0]=1 is flagged with err at completion. It still takes the full
//   latency, does not write memory, and forces data_out to 16'h0000. When the
//   macro is undefined, addr[0] is ignored and err is tied low.
//
// Parameters
//   LATENCY  cycles from acceptance to done (1..15)
//   AW       word-address bits, memory depth 2^AW x 16-bit
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req       in   access request valid
//   wr        in   1 = write, 0 = read (sampled with req)
//   addr      in   16-bit byte address (sampled with req)
//   data_in   in   write data (sampled with req)
//   flush     in   abort in-flight access, also blocks req in the same cycle
//   data_out  out  registered read data, held until the next read completes
//   stall     out  high while BUSY
//   done      out  completion pulse (state RESP)
//   err       out  unaligned-error pulse, only with done
//   dbg_state out  current FSM state encoding for observation
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int LATENCY = 3,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        flush,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            unal_q, unal_d;
    logic [15:0]     data_out_q;
    logic            err_q;

    logic [15:0]     mem [0:(1<<AW)-1];

    logic            accept;
    logic            req_unal;
    logic            fin_en;
    logic            fin_wr;
    logic            fin_unal;
    logic [AW-1:0]   fin_idx;
    logic [15:0]     fin_data;
    logic            unused_addr;

`ifdef IMEM_UNALIGNED_ERR_EN
    assign req_unal = addr[0];
`else
    assign req_unal = 1'b0;
`endif

    // Upper address bits alias onto the array and are intentionally dropped.
    assign unused_addr = ^addr;

    assign accept = req && !flush && (state_q != BUSY);

    // With LATENCY=1 the access completes on its acceptance edge, so the
    // commit uses the live request fields instead of the captured copies.
    assign fin_wr   = (LATENCY == 1) ? wr       : wr_q;
    assign fin_idx  = (LATENCY == 1) ? addr[AW:1] : idx_q;
    assign fin_data = (LATENCY == 1) ? data_in  : wdata_q;
    assign fin_unal = (LATENCY == 1) ? req_unal : unal_q;
    assign fin_en   = !rst && ((LATENCY == 1) ? accept
                                : (state_q == BUSY && cnt_q == 4'd1 && !flush));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unal_d  = unal_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    wr_d    = wr;
                    idx_d   = addr[AW:1];
                    wdata_d = data_in;
                    unal_d  = req_unal;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 16'h0000;
            unal_q     <= 1'b0;
            data_out_q <= 16'h0000;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            unal_q  <= unal_d;
            err_q   <= fin_en && fin_unal;
            // Reads load the array word; an unaligned access of either kind
            // forces zero so stale data is never mistaken for a response.
            if (fin_en && (fin_unal || !fin_wr))
                data_out_q <= fin_unal ? 16'h0000 : mem[fin_idx];
        end
    end

    // Array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (fin_en && fin_wr && !fin_unal)
            mem[fin_idx] <= fin_data;
    end

    assign data_out  = data_out_q;
    assign stall     = (state_q == BUSY);
    assign done      = (state_q == RESP);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (LATENCY=3, AW=8). Inputs are driven and
// outputs sampled on the falling edge, so the value seen at the k-th falling
// edge after driving a request belongs to cycle T+k.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        flush;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    imem_responder #(.LATENCY(3), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .flush     (flush),
        .data_out  (data_out),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
        req     = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    // full write, checked for completion at exactly T+3
    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        start(1'b1, a, d);
        tick(); req = 1'b0;
        tick();
        tick();
        chk("wr_done", {15'd0, done}, 16'd1);
        tick();
    endtask

    logic [15:0] exp_unal_data;
    logic        exp_unal_err;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0; flush = 1'b0;
        tick();
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_state", {14'd0, dbg_state}, 16'd0);
        rst = 1'b0;
        tick();

        // preload mem[0x10] and mem[0x11]
        do_write(16'h0020, 16'hABCD);
        chk("wr_keeps_data_out", data_out, 16'h0000);
        do_write(16'h0022, 16'h5555);

        // basic read latency
        start(1'b0, 16'h0020, 16'h0);
        tick(); req = 1'b0;
        chk("rd_stall_t1", {15'd0, stall}, 16'd1);
        chk("rd_nodone_t1", {15'd0, done}, 16'd0);
        tick();
        chk("rd_stall_t2", {15'd0, stall}, 16'd1);
        tick();
        chk("rd_done_t3", {15'd0, done}, 16'd1);
        chk("rd_stall_t3", {15'd0, stall}, 16'd0);
        chk("rd_data_t3", data_out, 16'hABCD);
        chk("rd_err_t3", {15'd0, err}, 16'd0);
        tick();
        chk("rd_done_pulse", {15'd0, done}, 16'd0);

        // back-to-back: second request presented in the done cycle
        start(1'b0, 16'h0020, 16'h0);
        tick(); req = 1'b0;
        tick();
        tick();
        chk("b2b_done1", {15'd0, done}, 16'd1);
        chk("b2b_data1", data_out, 16'hABCD);
        start(1'b0, 16'h0022, 16'h0);
        tick(); req = 1'b0;
        chk("b2b_stall", {15'd0, stall}, 16'd1);
        tick();
        tick();
        chk("b2b_done2", {15'd0, done}, 16'd1);
        chk("b2b_data2", data_out, 16'h5555);
        tick();

        // flush during BUSY
        start(1'b0, 16'h0020, 16'h0);
        tick(); req = 1'b0;
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("fl_stall_t2", {15'd0, stall}, 16'd0);
        chk("fl_nodone_t2", {15'd0, done}, 16'd0);
        tick();
        chk("fl_nodone_t3", {15'd0, done}, 16'd0);
        chk("fl_data_kept", data_out, 16'h5555);
        tick();

        // req while BUSY is dropped, not queued
        start(1'b0, 16'h0020, 16'h0);
        tick();
        addr = 16'h0022;
        tick(); req = 1'b0;
        tick();
        chk("busy_req_done", {15'd0, done}, 16'd1);
        chk("busy_req_data", data_out, 16'hABCD);
        tick();
        chk("busy_req_noqueue", {15'd0, done | stall}, 16'd0);

        // flush in RESP: done still shown, simultaneous req ignored
        start(1'b0, 16'h0022, 16'h0);
        tick(); req = 1'b0;
        tick();
        tick();
        req = 1'b1; flush = 1'b1;
        chk("resp_flush_done", {15'd0, done}, 16'd1);
        tick(); req = 1'b0; flush = 1'b0;
        chk("resp_flush_idle", {14'd0, dbg_state}, 16'd0);
        chk("resp_flush_nostall", {15'd0, stall}, 16'd0);
        tick();

        // unaligned read
`ifdef IMEM_UNALIGNED_ERR_EN
        exp_unal_data = 16'h0000; exp_unal_err = 1'b1;
`else
        exp_unal_data = 16'hABCD; exp_unal_err = 1'b0;
`endif
        start(1'b0, 16'h0021, 16'h0);
        tick(); req = 1'b0;
        tick();
        tick();
        chk("unal_done", {15'd0, done}, 16'd1);
        chk("unal_err", {15'd0, err}, {15'd0, exp_unal_err});
        chk("unal_data", data_out, exp_unal_data);
        tick();
        chk("unal_err_pulse", {15'd0, err}, 16'd0);

        // async reset in the middle of a write
        do_write(16'h0040, 16'h7777);
        start(1'b1, 16'h0040, 16'hDEAD);
        tick(); req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_stall", {15'd0, stall}, 16'd0);
        chk("arst_done", {15'd0, done}, 16'd0);
        chk("arst_err", {15'd0, err}, 16'd0);
        chk("arst_data", data_out, 16'h0000);
        tick(); rst = 1'b0;
        tick();
        chk("arst_nodone", {15'd0, done}, 16'd0);
        start(1'b0, 16'h0040, 16'h0);
        tick(); req = 1'b0;
        tick();
        tick();
        chk("arst_rd_done", {15'd0, done}, 16'd1);
        chk("arst_rd_data", data_out, 16'h7777);
        tick();

        // address aliasing above bit AW
        do_write(16'h0202, 16'h1234);
        start(1'b0, 16'h0002, 16'h0);
        tick(); req = 1'b0;
        tick();
        tick();
        chk("alias_done", {15'd0, done}, 16'd1);
        chk("alias_data", data_out, 16'h1234);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
